// File: rtl/mem_master.sv
// Queues client requests in a 2-entry FIFO and runs them one at a time against a start/complete memory port.
// A request takes 4 cycles from acceptance to response when memory completes at once; req_ready drops while the FIFO is full.
module mem_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [29:0] req_addr,
  input  logic        req_read,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_read,
  output logic        rsp_error,
  output logic [29:0] mem_addr,
  output logic        mem_readOrWrite,
  output logic        mem_start,
  output logic [63:0] mem_wData,
  input  logic [63:0] mem_rData,
  input  logic        mem_complete,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The last WAIT cycle is the one whose increment would make the counter equal TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [29:0] fifo_addr_q  [2];
  logic        fifo_read_q  [2];
  logic [63:0] fifo_wdata_q [2];
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic        mem_rw_q, mem_rw_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_read_q, rsp_read_d;
  logic        rsp_error_q, rsp_error_d;
  logic        push, pop;

  assign req_ready = (count_q != 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == RESP);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = mem_rw_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_read_d  = rsp_read_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          state_d     = ISSUE;
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_rw_d    = fifo_read_q[rd_ptr_q];
          mem_wdata_d = fifo_wdata_q[rd_ptr_q];
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = 8'd0;
      end
      WAIT: begin
        // Completion beats timeout when both land in the same cycle.
        if (mem_complete) begin
          state_d     = RESP;
          rsp_data_d  = mem_rw_q ? mem_rData : 64'd0;
          rsp_read_d  = mem_rw_q;
          rsp_error_d = 1'b0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d     = RESP;
          rsp_data_d  = 64'd0;
          rsp_read_d  = mem_rw_q;
          rsp_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wait_cnt_q  <= 8'd0;
      mem_addr_q  <= 30'd0;
      mem_rw_q    <= 1'b1;
      mem_wdata_q <= 64'd0;
      rsp_data_q  <= 64'd0;
      rsp_read_q  <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_read_q  <= rsp_read_d;
      rsp_error_q <= rsp_error_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_read_q[wr_ptr_q]  <= req_read;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  assign mem_start       = (state_q == ISSUE);
  assign mem_addr        = mem_addr_q;
  assign mem_readOrWrite = mem_rw_q;
  assign mem_wData       = mem_wdata_q;
  assign rsp_valid       = (state_q == RESP);
  assign rsp_data        = rsp_data_q;
  assign rsp_read        = rsp_read_q;
  assign rsp_error       = rsp_error_q;
  assign busy            = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with TIMEOUT = 4; inputs driven and outputs sampled on the falling edge.
module tb_mem_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [29:0] req_addr = '0;
  logic        req_read = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_read;
  logic        rsp_error;
  logic [29:0] mem_addr;
  logic        mem_readOrWrite;
  logic        mem_start;
  logic [63:0] mem_wData;
  logic [63:0] mem_rData = '0;
  logic        mem_complete = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_master #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_read(req_read), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_read(rsp_read), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_readOrWrite(mem_readOrWrite), .mem_start(mem_start),
    .mem_wData(mem_wData), .mem_rData(mem_rData), .mem_complete(mem_complete),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0h want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h want 0", busy); end
    checks++; if (mem_start !== 1'b0) begin errors++; $display("FAIL rst_mem_start got %0h want 0", mem_start); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0h want 0", rsp_valid); end
    checks++; if ({rsp_read, rsp_error} !== 2'b00) begin errors++; $display("FAIL rst_rsp_flags got %0h want 0", {rsp_read, rsp_error}); end
    checks++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
    checks++; if (mem_addr !== 30'd0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wData !== 64'd0) begin errors++; $display("FAIL rst_mem_wData got %h want 0", mem_wData); end
    checks++; if (mem_readOrWrite !== 1'b1) begin errors++; $display("FAIL rst_mem_rw got %0h want 1", mem_readOrWrite); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready_after got %0h want 1", req_ready); end
  endtask

  task automatic test_single_read();
    req_valid = 1'b1; req_addr = 30'h10; req_read = 1'b1; req_wdata = 64'd0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_start !== 1'b0) begin errors++; $display("FAIL rd_early_start got %0h want 0", mem_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %0h want 1", busy); end
    @(negedge clk);
    checks++; if (mem_start !== 1'b1) begin errors++; $display("FAIL rd_start got %0h want 1", mem_start); end
    checks++; if (mem_addr !== 30'h10) begin errors++; $display("FAIL rd_addr got %h want 10", mem_addr); end
    checks++; if (mem_readOrWrite !== 1'b1) begin errors++; $display("FAIL rd_rw got %0h want 1", mem_readOrWrite); end
    @(negedge clk);
    checks++; if (mem_start !== 1'b0) begin errors++; $display("FAIL rd_start_one_cycle got %0h want 0", mem_start); end
    mem_complete = 1'b1; mem_rData = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    mem_complete = 1'b0; mem_rData = 64'h0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got %0h want 1", rsp_valid); end
    checks++; if (rsp_data !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_rsp_data got %h want deadbeefcafef00d", rsp_data); end
    checks++; if ({rsp_read, rsp_error} !== 2'b10) begin errors++; $display("FAIL rd_rsp_flags got %b want 10", {rsp_read, rsp_error}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_one_cycle got %0h want 0", rsp_valid); end
    checks++; if (rsp_data !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_rsp_hold got %h want deadbeefcafef00d", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_busy got %0h want 0", busy); end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_addr = 30'h3FFFFFFF; req_read = 1'b0; req_wdata = 64'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_start !== 1'b1) begin errors++; $display("FAIL wr_start got %0h want 1", mem_start); end
    checks++; if (mem_addr !== 30'h3FFFFFFF) begin errors++; $display("FAIL wr_addr got %h want 3fffffff", mem_addr); end
    checks++; if (mem_wData !== 64'h1234) begin errors++; $display("FAIL wr_wdata got %h want 1234", mem_wData); end
    checks++; if (mem_readOrWrite !== 1'b0) begin errors++; $display("FAIL wr_rw got %0h want 0", mem_readOrWrite); end
    @(negedge clk);
    checks++; if (mem_wData !== 64'h1234) begin errors++; $display("FAIL wr_wdata_hold got %h want 1234", mem_wData); end
    mem_complete = 1'b1; mem_rData = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_complete = 1'b0; mem_rData = 64'h0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid got %0h want 1", rsp_valid); end
    checks++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL wr_rsp_data got %h want 0", rsp_data); end
    checks++; if ({rsp_read, rsp_error} !== 2'b00) begin errors++; $display("FAIL wr_rsp_flags got %b want 00", {rsp_read, rsp_error}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_addr = 30'h100; req_read = 1'b1; req_wdata = 64'd0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_1 got %0h want 1", req_ready); end
    req_addr = 30'h200;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %0h want 0", req_ready); end
    checks++; if (mem_start !== 1'b1 || mem_addr !== 30'h100) begin errors++; $display("FAIL b2b_start_a got %0h/%h want 1/100", mem_start, mem_addr); end
    req_addr = 30'h300;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_wait got %0h want 0", req_ready); end
    mem_complete = 1'b1; mem_rData = 64'hA;
    @(negedge clk);
    mem_complete = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_rsp_a got %0h/%0h want 1/0", rsp_valid, req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop got %0h want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_start !== 1'b1 || mem_addr !== 30'h200) begin errors++; $display("FAIL b2b_start_b got %0h/%h want 1/200", mem_start, mem_addr); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c_in got %0h want 0", req_ready); end
    @(negedge clk);
    mem_complete = 1'b1; mem_rData = 64'hB;
    @(negedge clk);
    mem_complete = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hB) begin errors++; $display("FAIL b2b_rsp_b got %0h/%h want 1/b", rsp_valid, rsp_data); end
    repeat (2) @(negedge clk);
    checks++; if (mem_start !== 1'b1 || mem_addr !== 30'h300) begin errors++; $display("FAIL b2b_start_c got %0h/%h want 1/300", mem_start, mem_addr); end
    @(negedge clk);
    mem_complete = 1'b1; mem_rData = 64'h0C0C_0C0C_0C0C_0C0C;
    @(negedge clk);
    mem_complete = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h0C0C_0C0C_0C0C_0C0C) begin errors++; $display("FAIL b2b_rsp_c got %0h/%h want 1/0c0c0c0c0c0c0c0c", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_addr = 30'h20; req_read = 1'b1;
    @(negedge clk);
    req_addr = 30'h21;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_start !== 1'b1 || mem_addr !== 30'h20) begin errors++; $display("FAIL to_start_x got %0h/%h want 1/20", mem_start, mem_addr); end
    mem_rData = 64'h7777_7777_7777_7777;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || mem_addr !== 30'h20) begin errors++; $display("FAIL to_wait_%0d got %0h/%h want 0/20", i, rsp_valid, mem_addr); end
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL to_rsp_valid got %0h want 1", rsp_valid); end
    checks++; if (rsp_error !== 1'b1 || rsp_data !== 64'd0) begin errors++; $display("FAIL to_rsp_err got %0h/%h want 1/0", rsp_error, rsp_data); end
    checks++; if (rsp_read !== 1'b1) begin errors++; $display("FAIL to_rsp_read got %0h want 1", rsp_read); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_start !== 1'b1 || mem_addr !== 30'h21) begin errors++; $display("FAIL to_start_y got %0h/%h want 1/21", mem_start, mem_addr); end
    // Stray completion during ISSUE must be ignored; the real one lands on the last WAIT cycle.
    mem_complete = 1'b1;
    @(negedge clk);
    mem_complete = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bnd_wait_%0d got %0h want 0", i, rsp_valid); end
      @(negedge clk);
    end
    mem_complete = 1'b1; mem_rData = 64'h5555_AAAA_0123_4567;
    @(negedge clk);
    mem_complete = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bnd_rsp_valid got %0h want 1", rsp_valid); end
    checks++; if (rsp_error !== 1'b0 || rsp_data !== 64'h5555_AAAA_0123_4567) begin errors++; $display("FAIL bnd_rsp got %0h/%h want 0/5555aaaa01234567", rsp_error, rsp_data); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bnd_idle got %0h want 0", busy); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 30'h30; req_read = 1'b1;
    @(negedge clk);
    req_addr = 30'h31;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_complete = 1'b1; mem_rData = 64'h9999;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after_rst got %0h/%0h want 0/0", rsp_valid, busy); end
    @(negedge clk);
    mem_complete = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || mem_start !== 1'b0) begin errors++; $display("FAIL mid_late_cmpl got %0h/%0h want 0/0", rsp_valid, mem_start); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_empty got %0h/%0h want 0/1", busy, req_ready); end
    req_valid = 1'b1; req_addr = 30'h40; req_read = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_start !== 1'b1 || mem_addr !== 30'h40) begin errors++; $display("FAIL mid_new_start got %0h/%h want 1/40", mem_start, mem_addr); end
    @(negedge clk);
    mem_complete = 1'b1; mem_rData = 64'h4040;
    @(negedge clk);
    mem_complete = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h4040 || rsp_error !== 1'b0) begin errors++; $display("FAIL mid_new_rsp got %0h/%h/%0h want 1/4040/0", rsp_valid, rsp_data, rsp_error); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles before a request is aborted with an error; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  client request present.
REQ-005 req_ready  output  1  queue can accept a request this cycle.
REQ-006 req_addr  input  30  word address (64-bit words).
REQ-007 req_read  input  1  1 = read, 0 = write.
REQ-008 req_wdata  input  64  write data; ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle response strobe.
REQ-010 rsp_data  output  64  read data; 0 for writes and for errors.
REQ-011 rsp_read  output  1  echo of req_read for the completed request.
REQ-012 rsp_error  output  1  request timed out.
REQ-013 mem_addr  output  30  address to memory.
REQ-014 mem_readOrWrite  output  1  1 = read, 0 = write.
REQ-015 mem_start  output  1  one-cycle request strobe to memory.
REQ-016 mem_wData  output  64  write data to memory.
REQ-017 mem_rData  input  64  read data; valid only when mem_complete = 1.
REQ-018 mem_complete  input  1  one-cycle completion strobe from memory.
REQ-019 busy  output  1  high whenever the state is not IDLE or the queue is non-empty.

Function
REQ-020 The block shall hold a 2-entry FIFO of {addr, read, wdata}; req_ready = (count < 2), computed from registered count only.
REQ-021 A push shall occur at an edge where req_valid && req_ready; the request is then visible at the head no earlier than the following cycle.
REQ-022 The FSM shall have states IDLE, ISSUE, WAIT and RESP, one outstanding memory transaction at a time, served in FIFO order.
REQ-023 IDLE -> ISSUE when the FIFO is non-empty; otherwise remain in IDLE.
REQ-024 ISSUE: mem_start = 1 for exactly this one cycle; mem_addr, mem_readOrWrite and mem_wData = head fields; next state WAIT; wait counter cleared to 0.
REQ-025 mem_addr, mem_readOrWrite and mem_wData shall be registered and held stable from ISSUE through the end of WAIT.
REQ-026 WAIT: on mem_complete = 1, capture mem_rData (reads) or 0 (writes), set error = 0, -> RESP.
REQ-027 WAIT without mem_complete: counter increments by 1; when the counter equals TIMEOUT, capture data = 0, error = 1, -> RESP; mem_complete in that same cycle takes priority over timeout.
REQ-028 mem_complete outside WAIT (including the ISSUE cycle) shall be ignored.
REQ-029 RESP: rsp_valid = 1 for exactly one cycle with captured data, rsp_read and rsp_error; pop the FIFO head; -> IDLE. There is no response backpressure.
REQ-030 A push and a pop at the same edge shall both take effect; count is unchanged.
REQ-031 Minimum latency: request accepted at edge E, mem_start in the cycle after E+1, rsp_valid two cycles after mem_start when memory completes in the cycle after start.
REQ-032 rsp_data, rsp_read and rsp_error shall hold their last values between strobes; only rsp_valid returns to 0.

Reset
REQ-033 On reset: state = IDLE; FIFO emptied (count 0, pointers 0); wait counter 0; mem_start, rsp_valid, rsp_error and rsp_read = 0; rsp_data, mem_addr and mem_wData = 0; mem_readOrWrite = 1; req_ready = 1 in the cycle after reset deasserts.
REQ-034 Reset asserted mid-transaction shall abandon the transaction with no response; a late mem_complete after reset shall be ignored (REQ-028).

Verification
REQ-035 Single read of addr 0x10, memory completes 1 cycle after start with 0xDEADBEEF_CAFEF00D -> one mem_start with mem_readOrWrite = 1, then rsp_valid with that data, rsp_error = 0.
REQ-036 Three back-to-back pushes with req_valid held -> req_ready falls after 2 accepted; third accepted after first RESP pop; mem_start order matches push order.
REQ-037 Write of 0x1234 to addr 0x3FFFFFFF -> mem_wData = 0x1234 and mem_readOrWrite = 0; rsp_data = 0 and rsp_read = 0.
REQ-038 TIMEOUT = 4 and memory never completes -> rsp_valid with rsp_error = 1 exactly 4 WAIT cycles after the start cycle; the next queued request then issues.
REQ-039 mem_complete in the same cycle the counter reaches TIMEOUT -> rsp_error = 0 with the captured data; stray mem_complete during ISSUE -> no response.
REQ-040 Reset asserted during WAIT -> no rsp_valid, FIFO empty, busy = 0; a new request issues normally afterward.
